// File: rtl/sobel_gradient_unit.sv
// Two-stage pipelined 3x3 Sobel edge-magnitude operator: stage 1 forms Gx/Gy,
// stage 2 forms |Gx|+|Gy|, saturates it, and zeroes border or invalid results.
module sobel_gradient_unit #(
   parameter int BIT_WIDTH = 8,
   parameter int SAT_MAX   = 2**BIT_WIDTH - 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   input  logic                 border,
   input  logic [BIT_WIDTH-1:0] p0,
   input  logic [BIT_WIDTH-1:0] p1,
   input  logic [BIT_WIDTH-1:0] p2,
   input  logic [BIT_WIDTH-1:0] p3,
   input  logic [BIT_WIDTH-1:0] p5,
   input  logic [BIT_WIDTH-1:0] p6,
   input  logic [BIT_WIDTH-1:0] p7,
   input  logic [BIT_WIDTH-1:0] p8,
   output logic [BIT_WIDTH-1:0] data_out,
   output logic                 out_valid
);

   // Four extra bits cover the x4 weight sum plus sign (12 bits for 8-bit pixels).
   localparam int GW = BIT_WIDTH + 4;
   localparam logic [GW-1:0]        SAT_LIM = GW'(SAT_MAX);
   localparam logic [BIT_WIDTH-1:0] SAT_OUT = BIT_WIDTH'(SAT_MAX);

   function automatic logic signed [GW-1:0] widen(input logic [BIT_WIDTH-1:0] p);
      return $signed({{(GW-BIT_WIDTH){1'b0}}, p});
   endfunction

   function automatic logic [GW-1:0] abs_val(input logic signed [GW-1:0] x);
      logic signed [GW-1:0] neg;
      neg = -x;
      return x[GW-1] ? $unsigned(neg) : $unsigned(x);
   endfunction

   function automatic logic [BIT_WIDTH-1:0] saturate(input logic [GW-1:0] mag);
      return (mag > SAT_LIM) ? SAT_OUT : mag[BIT_WIDTH-1:0];
   endfunction

   logic signed [GW-1:0] gx_c;
   logic signed [GW-1:0] gy_c;
   logic signed [GW-1:0] gx_p1;
   logic signed [GW-1:0] gy_p1;
   logic                 vld_p1;
   logic                 border_p1;
   logic [GW-1:0]        mag_c;

   // Doubling is a left shift; the centre pixel takes no part in either kernel.
   always_comb begin
      gx_c = (widen(p2) + (widen(p5) <<< 1) + widen(p8))
           - (widen(p0) + (widen(p3) <<< 1) + widen(p6));
      gy_c = (widen(p6) + (widen(p7) <<< 1) + widen(p8))
           - (widen(p0) + (widen(p1) <<< 1) + widen(p2));
   end

   // Stage 1: gradients and control registered unconditionally every clock.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         gx_p1     <= '0;
         gy_p1     <= '0;
         vld_p1    <= 1'b0;
         border_p1 <= 1'b0;
      end else begin
         gx_p1     <= gx_c;
         gy_p1     <= gy_c;
         vld_p1    <= in_valid;
         border_p1 <= border;
      end
   end

   always_comb begin
      mag_c = abs_val(gx_p1) + abs_val(gy_p1);
   end

   // Stage 2: saturated magnitude, forced to zero for bubbles and frame-edge pixels.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_out  <= '0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= vld_p1;
         if (vld_p1 && !border_p1) begin
            data_out <= saturate(mag_c);
         end else begin
            data_out <= '0;
         end
      end
   end

endmodule

// File: tb/tb_sobel_gradient_unit.sv
// Self-checking bench for sobel_gradient_unit: directed Sobel cases plus
// randomized streaming compared with a plain-arithmetic reference model.
module tb_sobel_gradient_unit;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic       border;
   logic [7:0] p0, p1, p2, p3, p5, p6, p7, p8;
   logic [7:0] data_out;
   logic       out_valid;

   int n_vec = 0;
   int n_bad = 0;

   typedef struct packed {
      logic       v;
      logic [7:0] d;
   } exp_t;

   exp_t       exp_q[$];
   logic       obs_v;
   logic [7:0] obs_d;

   sobel_gradient_unit #(.BIT_WIDTH(8), .SAT_MAX(255)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .border(border),
      .p0(p0), .p1(p1), .p2(p2), .p3(p3), .p5(p5), .p6(p6), .p7(p7), .p8(p8),
      .data_out(data_out), .out_valid(out_valid)
   );

   always #5 clk = ~clk;

   // Neighbourhood packed as nine bytes, byte i = pixel i (byte 4 unused).
   function automatic logic [71:0] pk(input int a0, input int a1, input int a2, input int a3,
                                      input int a5, input int a6, input int a7, input int a8);
      return {8'(a8), 8'(a7), 8'(a6), 8'(a5), 8'd0, 8'(a3), 8'(a2), 8'(a1), 8'(a0)};
   endfunction

   function automatic logic [7:0] ref_mag(input logic [71:0] px, input logic b, input logic v);
      int p[9];
      int gx, gy, mag;
      for (int i = 0; i < 9; i++) p[i] = int'(px[8*i +: 8]);
      gx  = (p[2] + 2*p[5] + p[8]) - (p[0] + 2*p[3] + p[6]);
      gy  = (p[6] + 2*p[7] + p[8]) - (p[0] + 2*p[1] + p[2]);
      mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
      if (!v || b) return 8'd0;
      if (mag > 255) return 8'd255;
      return 8'(mag);
   endfunction

   // Drives one sample, advances one edge, then checks the result due now.
   task automatic cycle(input logic v, input logic b, input logic [71:0] px);
      exp_t e;
      in_valid = v;
      border   = b;
      p0 = px[7:0];   p1 = px[15:8];  p2 = px[23:16]; p3 = px[31:24];
      p5 = px[47:40]; p6 = px[55:48]; p7 = px[63:56]; p8 = px[71:64];
      exp_q.push_back('{v: v, d: ref_mag(px, b, v)});
      @(posedge clk);
      #1;
      obs_v = out_valid;
      obs_d = data_out;
      if (exp_q.size() >= 2) begin
         e = exp_q.pop_front();
         n_vec++;
         if ({obs_v, obs_d} !== {e.v, e.d}) begin
            n_bad++;
            $display("FAIL pipeline t=%0t: out_valid/data_out=%0b/%0d expected %0b/%0d",
                     $time, obs_v, obs_d, e.v, e.d);
         end
      end
   endtask

   task automatic restart_model();
      exp_q.delete();
      exp_q.push_back('{v: 1'b0, d: 8'd0});
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; border = 1'b0;
      {p0, p1, p2, p3, p5, p6, p7, p8} = '0;
      #12;
      n_vec++;
      if (out_valid !== 1'b0 || data_out !== 8'd0) begin
         n_bad++;
         $display("FAIL reset_state: out_valid/data_out=%0b/%0d expected 0/0", out_valid, data_out);
      end
      @(negedge clk);
      rst = 1'b0;
      restart_model();
   endtask

   task automatic test_flat();
      cycle(1'b1, 1'b0, pk(100, 100, 100, 100, 100, 100, 100, 100));
      cycle(1'b0, 1'b0, '0);
      n_vec++;
      if (obs_v !== 1'b1 || obs_d !== 8'd0) begin
         n_bad++;
         $display("FAIL flat_patch: out_valid/data_out=%0b/%0d expected 1/0", obs_v, obs_d);
      end
   endtask

   task automatic test_vertical_edge();
      cycle(1'b1, 1'b0, pk(0, 128, 255, 0, 255, 0, 128, 255));
      cycle(1'b0, 1'b0, '0);
      n_vec++;
      if (obs_v !== 1'b1 || obs_d !== 8'd255) begin
         n_bad++;
         $display("FAIL vertical_edge: out_valid/data_out=%0b/%0d expected 1/255", obs_v, obs_d);
      end
   endtask

   task automatic test_small_gradient();
      cycle(1'b1, 1'b0, pk(0, 0, 10, 0, 0, 0, 0, 0));
      cycle(1'b1, 1'b0, pk(0, 0, 0, 0, 0, 0, 30, 0));
      n_vec++;
      if (obs_d !== 8'd20) begin
         n_bad++;
         $display("FAIL small_gradient_a: data_out=%0d expected 20", obs_d);
      end
      cycle(1'b0, 1'b0, '0);
      n_vec++;
      if (obs_d !== 8'd60) begin
         n_bad++;
         $display("FAIL small_gradient_b: data_out=%0d expected 60", obs_d);
      end
   endtask

   task automatic test_border();
      cycle(1'b1, 1'b1, pk(0, 128, 255, 0, 255, 0, 128, 255));
      cycle(1'b1, 1'b0, pk(0, 128, 255, 0, 255, 0, 128, 255));
      n_vec++;
      if (obs_v !== 1'b1 || obs_d !== 8'd0) begin
         n_bad++;
         $display("FAIL border_forced: out_valid/data_out=%0b/%0d expected 1/0", obs_v, obs_d);
      end
      cycle(1'b0, 1'b0, '0);
      n_vec++;
      if (obs_v !== 1'b1 || obs_d !== 8'd255) begin
         n_bad++;
         $display("FAIL border_release: out_valid/data_out=%0b/%0d expected 1/255", obs_v, obs_d);
      end
   endtask

   task automatic test_streaming_bubbles();
      logic [8:0] pattern;
      logic [8:0] seen;
      pattern = 9'b111011111;
      seen    = '0;
      for (int i = 0; i < 9; i++) begin
         cycle(pattern[i], 1'b0, {$urandom, $urandom, $urandom});
         if (i >= 1) seen[i-1] = obs_v;
      end
      cycle(1'b0, 1'b0, '0);
      seen[8] = obs_v;
      n_vec++;
      if (seen !== pattern) begin
         n_bad++;
         $display("FAIL bubble_pattern: out_valid sequence=%b expected %b", seen, pattern);
      end
      cycle(1'b0, 1'b0, '0);
   endtask

   task automatic test_back_to_back();
      logic [71:0] px;
      for (int i = 0; i < 300; i++) begin
         px = {$urandom, $urandom, $urandom};
         if ($urandom_range(0, 3) == 0) begin
            for (int k = 0; k < 9; k++) px[8*k +: 8] = ($urandom_range(0, 1) != 0) ? 8'd255 : 8'd0;
         end
         cycle($urandom_range(0, 7) != 0, $urandom_range(0, 7) == 0, px);
      end
      cycle(1'b0, 1'b0, '0);
   endtask

   task automatic test_midstream_reset();
      cycle(1'b1, 1'b0, pk(0, 128, 255, 0, 255, 0, 128, 255));
      cycle(1'b1, 1'b0, pk(0, 0, 10, 0, 0, 0, 0, 0));
      n_vec++;
      if (obs_v !== 1'b1 || obs_d !== 8'd255) begin
         n_bad++;
         $display("FAIL pre_reset_output: out_valid/data_out=%0b/%0d expected 1/255", obs_v, obs_d);
      end
      in_valid = 1'b1;
      #2;
      rst = 1'b1;
      #1;
      n_vec++;
      if (out_valid !== 1'b0 || data_out !== 8'd0) begin
         n_bad++;
         $display("FAIL async_reset: out_valid/data_out=%0b/%0d expected 0/0", out_valid, data_out);
      end
      @(posedge clk);
      #1;
      n_vec++;
      if (out_valid !== 1'b0 || data_out !== 8'd0) begin
         n_bad++;
         $display("FAIL reset_hold: out_valid/data_out=%0b/%0d expected 0/0", out_valid, data_out);
      end
      @(negedge clk);
      rst = 1'b0;
      restart_model();
      cycle(1'b0, 1'b0, '0);
      cycle(1'b1, 1'b0, pk(0, 0, 0, 0, 0, 0, 30, 0));
      cycle(1'b0, 1'b0, '0);
      n_vec++;
      if (obs_v !== 1'b1 || obs_d !== 8'd60) begin
         n_bad++;
         $display("FAIL post_reset_result: out_valid/data_out=%0b/%0d expected 1/60", obs_v, obs_d);
      end
      cycle(1'b0, 1'b0, '0);
   endtask

   initial begin
      test_reset();
      test_flat();
      test_vertical_edge();
      test_small_gradient();
      test_border();
      test_streaming_bubbles();
      test_back_to_back();
      test_midstream_reset();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
